// File: rtl/seg_scan_driver_pkg.sv
// Shared display definitions for the multiplexed seven-segment scan driver:
// active-low segment glyphs, scan FSM states and anode helpers.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit glyphs, active-low, bit order DP g f e d c b a
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] SEG_L = 8'hC7;
  localparam logic [7:0] SEG_O = 8'hC0;
  localparam logic [7:0] SEG_S = 8'h92;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_Y = 8'h91;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_P = 8'h8C;
  localparam logic [7:0] SEG_D = 8'hA1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  typedef logic [3:0] anode_t;

  localparam anode_t ANODE_OFF = 4'hF;

  // Digit 0 is leftmost and owns An[3]
  function automatic anode_t anode_select(input logic [1:0] dig);
    anode_t an;
    case (dig)
      2'd0:    an = 4'b0111;
      2'd1:    an = 4'b1011;
      2'd2:    an = 4'b1101;
      2'd3:    an = 4'b1110;
      default: an = ANODE_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_pwm_gate.sv
// Brightness gate: free-running 4-bit phase counter compared against Duty.
// The gate is combinational; the top registers it together with An.
module seg_pwm_gate
  import seg_scan_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] duty,
  output logic       gate_on
);

  logic [3:0] phase_r;

  // Phase counter runs regardless of scan enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= 4'd0;
    end else begin
      phase_r <= phase_r + 4'd1;
    end
  end

  // Duty 15 is full on rather than 15/16
  always_comb begin
    gate_on = 1'b0;
    if (duty == 4'd15) begin
      gate_on = 1'b1;
    end else begin
      gate_on = (phase_r < duty);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-slot anti-ghost
// blanking, frame-atomic shadow latching and PWM brightness gating.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       En,
  input  logic [3:0] Duty,
  input  logic [7:0] segIn0,
  input  logic [7:0] segIn1,
  input  logic [7:0] segIn2,
  input  logic [7:0] segIn3,
  output logic [3:0] An,
  output logic [7:0] Seg,
  output logic       FrameStart
);

  localparam int unsigned TICK_W = $clog2(DIGIT_CYCLES);

  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_next_s;
  logic              tick_last_s;
  logic [1:0]        dig_r;
  scan_state_t       state_r;
  logic [7:0]        shadow0_r;
  logic [7:0]        shadow1_r;
  logic [7:0]        shadow2_r;
  logic [7:0]        shadow3_r;
  logic [7:0]        drive_word_s;
  logic              frame_latch_s;
  logic              gate_on_s;
  anode_t            an_next_s;
  logic [7:0]        seg_next_s;

  seg_pwm_gate u_pwm_gate (
    .clk     (Clk100M),
    .rst_n   (Rst_n),
    .duty    (Duty),
    .gate_on (gate_on_s)
  );

  // Slot counter next value and wrap detection
  always_comb begin
    tick_last_s = (tick_r == TICK_W'(DIGIT_CYCLES - 1));
    if (tick_last_s) begin
      tick_next_s = '0;
    end else begin
      tick_next_s = tick_r + TICK_W'(1);
    end
    frame_latch_s = En && (tick_r == '0) && (dig_r == 2'd0);
  end

  // Select the shadow word and gated anode for the current slot
  always_comb begin
    case (dig_r)
      2'd0:    drive_word_s = shadow0_r;
      2'd1:    drive_word_s = shadow1_r;
      2'd2:    drive_word_s = shadow2_r;
      2'd3:    drive_word_s = shadow3_r;
      default: drive_word_s = SEG_BLANK;
    endcase
    if (state_r == ST_DRIVE) begin
      seg_next_s = drive_word_s;
      if (gate_on_s) begin
        an_next_s = anode_select(dig_r);
      end else begin
        an_next_s = ANODE_OFF;
      end
    end else begin
      seg_next_s = SEG_BLANK;
      an_next_s  = ANODE_OFF;
    end
  end

  // Shadows only move at a frame boundary so all digits change together
  always_ff @(posedge Clk100M) begin
    if (!Rst_n) begin
      shadow0_r <= SEG_BLANK;
      shadow1_r <= SEG_BLANK;
      shadow2_r <= SEG_BLANK;
      shadow3_r <= SEG_BLANK;
    end else if (frame_latch_s) begin
      shadow0_r <= segIn0;
      shadow1_r <= segIn1;
      shadow2_r <= segIn2;
      shadow3_r <= segIn3;
    end else begin
      shadow0_r <= shadow0_r;
      shadow1_r <= shadow1_r;
      shadow2_r <= shadow2_r;
      shadow3_r <= shadow3_r;
    end
  end

  // Scan FSM with counters and registered display outputs
  always_ff @(posedge Clk100M) begin
    if (!Rst_n) begin
      tick_r     <= '0;
      dig_r      <= 2'd0;
      state_r    <= ST_BLANK;
      An         <= ANODE_OFF;
      Seg        <= SEG_BLANK;
      FrameStart <= 1'b0;
    end else if (!En) begin
      tick_r     <= '0;
      dig_r      <= 2'd0;
      state_r    <= ST_BLANK;
      An         <= ANODE_OFF;
      Seg        <= SEG_BLANK;
      FrameStart <= 1'b0;
    end else begin
      tick_r     <= tick_next_s;
      An         <= an_next_s;
      Seg        <= seg_next_s;
      FrameStart <= frame_latch_s;
      if (tick_last_s) begin
        dig_r <= dig_r + 2'd1;
      end else begin
        dig_r <= dig_r;
      end
      case (state_r)
        ST_BLANK: begin
          if (tick_next_s == TICK_W'(BLANK_CYCLES)) begin
            state_r <= ST_DRIVE;
          end else begin
            state_r <= ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (tick_last_s) begin
            state_r <= ST_BLANK;
          end else begin
            state_r <= ST_DRIVE;
          end
        end
        default: state_r <= ST_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a slot-position reference model.
module tb_seg_scan_driver;

  localparam int DC = 8;
  localparam int BC = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] duty;
  logic [7:0] seg_in [4];
  logic [3:0] An;
  logic [7:0] Seg;
  logic       FrameStart;

  int total;
  int bad;

  // Reference model state: position within the 4*DC frame, brightness phase, shadows
  int         pos;
  int         phase;
  logic [7:0] sh [4];
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_fs;

  seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .Clk100M   (clk),
    .Rst_n     (rst_n),
    .En        (en),
    .Duty      (duty),
    .segIn0    (seg_in[0]),
    .segIn1    (seg_in[1]),
    .segIn2    (seg_in[2]),
    .segIn3    (seg_in[3]),
    .An        (An),
    .Seg       (Seg),
    .FrameStart(FrameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_model();
    int t;
    int d;
    int p;
    @(posedge clk);
    exp_an  = 4'hF;
    exp_seg = 8'hFF;
    exp_fs  = 1'b0;
    if (!rst_n) begin
      pos   = 0;
      phase = 0;
      for (int i = 0; i < 4; i++) sh[i] = 8'hFF;
    end else begin
      p     = phase;
      phase = (phase + 1) % 16;
      if (!en) begin
        pos = 0;
      end else begin
        t = pos % DC;
        d = (pos / DC) % 4;
        if (pos == 0) begin
          exp_fs = 1'b1;
          for (int i = 0; i < 4; i++) sh[i] = seg_in[i];
        end
        if (t >= BC) begin
          exp_seg = sh[d];
          if (duty == 4'd15 || p < duty) exp_an[3 - d] = 1'b0;
        end
        pos = (pos + 1) % (4 * DC);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to_pos(input int target);
    int n;
    n = 0;
    while (pos != target && n < 200) begin
      tick_model();
      n++;
    end
    total++;
    if (pos != target) begin
      bad++;
      $display("FAIL run_to_pos: reached pos=%0d wanted %0d", pos, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    duty = 4'd15;
    seg_in[0] = 8'hC0; seg_in[1] = 8'hF9; seg_in[2] = 8'hA4; seg_in[3] = 8'hB0;
    for (int i = 0; i < 3; i++) begin
      tick_model();
      total++;
      if (An !== 4'hF || Seg !== 8'hFF || FrameStart !== 1'b0) begin
        bad++;
        $display("FAIL reset: An=%h Seg=%h fs=%b want An=F Seg=FF fs=0", An, Seg, FrameStart);
      end
    end
  endtask

  task automatic test_basic_scan();
    rst_n = 1'b1;
    tick_model();
    total++;
    if (FrameStart !== 1'b1 || An !== 4'hF || Seg !== 8'hFF) begin
      bad++;
      $display("FAIL first_frame: An=%h Seg=%h fs=%b want An=F Seg=FF fs=1", An, Seg, FrameStart);
    end
    for (int i = 1; i < 64; i++) begin
      tick_model();
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL basic_scan cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
      if (i == 8 + BC) begin
        total++;
        if (An !== 4'b1011 || Seg !== 8'hF9) begin
          bad++;
          $display("FAIL basic_dig1: An=%h Seg=%h want An=B Seg=F9", An, Seg);
        end
      end
    end
  endtask

  task automatic test_atomic_update();
    int fs_count;
    run_to_pos(2 * DC + 3);
    seg_in[1] = 8'h92;
    fs_count = 0;
    for (int i = 0; i < 32; i++) begin
      tick_model();
      if (FrameStart === 1'b1) fs_count++;
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL atomic cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
    end
    total++;
    if (fs_count != 1) begin
      bad++;
      $display("FAIL atomic_fs_count: got %0d want 1", fs_count);
    end
  endtask

  task automatic test_brightness();
    duty = 4'd4;
    for (int i = 0; i < 64; i++) begin
      tick_model();
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL duty4 cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
    end
    duty = 4'd0;
    tick_model();
    for (int i = 0; i < 32; i++) begin
      tick_model();
      total++;
      if (An !== 4'hF || Seg !== exp_seg) begin
        bad++;
        $display("FAIL duty0 cyc%0d: An=%h Seg=%h want An=F Seg=%h", i, An, Seg, exp_seg);
      end
    end
    duty = 4'd15;
  endtask

  task automatic test_enable();
    run_to_pos(2 * DC + 5);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_model();
      total++;
      if (An !== 4'hF || Seg !== 8'hFF || FrameStart !== 1'b0) begin
        bad++;
        $display("FAIL en_low cyc%0d: An=%h Seg=%h fs=%b want An=F Seg=FF fs=0", i, An, Seg, FrameStart);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick_model();
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL en_rise cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
      if (i == 0) begin
        total++;
        if (FrameStart !== 1'b1) begin
          bad++;
          $display("FAIL en_rise_fs: fs=%b want 1", FrameStart);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    run_to_pos(3 * DC + 4);
    rst_n = 1'b0;
    tick_model();
    total++;
    if (An !== 4'hF || Seg !== 8'hFF || FrameStart !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: An=%h Seg=%h fs=%b want An=F Seg=FF fs=0", An, Seg, FrameStart);
    end
    rst_n = 1'b1;
    seg_in[0] = 8'h88; seg_in[1] = 8'h8C; seg_in[2] = 8'hC7; seg_in[3] = 8'h86;
    for (int i = 0; i < 40; i++) begin
      tick_model();
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL after_reset cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) duty = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) seg_in[k] = 8'($urandom);
      tick_model();
      total++;
      if (An !== exp_an || Seg !== exp_seg || FrameStart !== exp_fs) begin
        bad++;
        $display("FAIL random cyc%0d: An=%h Seg=%h fs=%b want An=%h Seg=%h fs=%b",
                 i, An, Seg, FrameStart, exp_an, exp_seg, exp_fs);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pos   = 0;
    phase = 0;
    for (int i = 0; i < 4; i++) sh[i] = 8'hFF;
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_atomic_update();
    test_brightness();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
